// File: rtl/vga_timmeas.sv
// vga_timmeas: receive-side timing measurement for one VGA axis.
// Recovers sync / back-porch / visible / front-porch lengths from a
// sync_i + vis_i stream, raises lock_o after LOCK_CNT identical lines and
// pulses err_o on malformed sequences or counter overflow.
// Optional build macro: VGA_TIMMEAS_SYNC2_EN puts 2-flop synchronizers on
// sync_i and vis_i, which delays every input-to-output path by 2 cycles.
module vga_timmeas #(
    parameter int LOCK_CNT     = 2,
    parameter int VGA_TB_WIDTH = 8,
    parameter int VGA_VB_WIDTH = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic                    sync_i,
    input  logic                    vis_i,
    output logic [VGA_TB_WIDTH-1:0] snsize_o,
    output logic [VGA_TB_WIDTH-1:0] bpsize_o,
    output logic [VGA_VB_WIDTH-1:0] vlen_o,
    output logic [VGA_TB_WIDTH-1:0] fpsize_o,
    output logic                    valid_o,
    output logic                    lock_o,
    output logic                    err_o
);

    // Largest count a porch/sync field can hold, expressed at counter width
    localparam logic [VGA_VB_WIDTH-1:0] TB_MAX  =
        VGA_VB_WIDTH'((64'd1 << VGA_TB_WIDTH) - 64'd1);
    localparam logic [VGA_VB_WIDTH-1:0] VB_MAX  = '1;
    localparam logic [3:0]              LOCK_TH = 4'(LOCK_CNT);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_BP, S_VIS, S_FP} state_t;

    state_t                  r_state;
    logic [VGA_VB_WIDTH-1:0] r_cnt;
    logic [VGA_TB_WIDTH-1:0] r_sn;
    logic [VGA_TB_WIDTH-1:0] r_bp;
    logic [VGA_VB_WIDTH-1:0] r_vl;
    logic [3:0]              r_match;

    logic                    w_s;
    logic                    w_v;
    logic                    w_tb_max;
    logic                    w_vb_max;
    logic                    w_err;
    logic                    w_done;
    logic [VGA_VB_WIDTH-1:0] w_vl;
    logic [VGA_TB_WIDTH-1:0] w_fp;
    logic                    w_same;
    logic [3:0]              w_match_nxt;
    logic                    w_lock_nxt;

`ifdef VGA_TIMMEAS_SYNC2_EN
    logic [1:0] r_s_sync;
    logic [1:0] r_v_sync;

    // Two-flop synchronizers for the asynchronous sync / vis inputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s_sync <= 2'b00;
            r_v_sync <= 2'b00;
        end else begin
            r_s_sync <= {r_s_sync[0], sync_i};
            r_v_sync <= {r_v_sync[0], vis_i};
        end
    end

    assign w_s = r_s_sync[1];
    assign w_v = r_v_sync[1];
`else
    assign w_s = sync_i;
    assign w_v = vis_i;
`endif

    assign w_tb_max = (r_cnt == TB_MAX);
    assign w_vb_max = (r_cnt == VB_MAX);

    // Classify the current sample: protocol/overflow error, line completion,
    // and the visible / front-porch values to report on completion
    always_comb begin
        w_err  = 1'b0;
        w_done = 1'b0;
        w_vl   = r_vl;
        w_fp   = '0;
        case (r_state)
            S_SYNC: w_err = w_s & (w_v | w_tb_max);
            S_BP:   w_err = w_s | (~w_v & w_tb_max);
            S_VIS: begin
                // sync straight after visible closes the line with no front porch
                w_err  = w_v & (w_s | w_vb_max);
                w_done = ~w_v & w_s;
                w_vl   = r_cnt;
            end
            S_FP: begin
                w_err  = w_v | (~w_s & w_tb_max);
                w_done = ~w_v & w_s;
                w_fp   = r_cnt[VGA_TB_WIDTH-1:0];
            end
            default: ;
        endcase
    end

    // New quadruple versus the one currently presented on the outputs
    assign w_same = (r_sn == snsize_o) && (r_bp == bpsize_o) &&
                    (w_vl == vlen_o)   && (w_fp == fpsize_o);

    // Match counter update; a zero count means first line since IDLE
    always_comb begin
        if (r_match == 4'd0 || !w_same) w_match_nxt = 4'd1;
        else if (r_match == 4'hF)       w_match_nxt = r_match;
        else                            w_match_nxt = r_match + 4'd1;
    end

    assign w_lock_nxt = (r_match != 4'd0 && !w_same) ? 1'b0 : (w_match_nxt >= LOCK_TH);

    // Measurement FSM with registered result, lock and error outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sn     <= '0;
            r_bp     <= '0;
            r_vl     <= '0;
            r_match  <= '0;
            snsize_o <= '0;
            bpsize_o <= '0;
            vlen_o   <= '0;
            fpsize_o <= '0;
            valid_o  <= 1'b0;
            lock_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            if (!en_i) begin
                // disable wins over any completion or error on this sample
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_match <= '0;
                lock_o  <= 1'b0;
            end else if (w_err) begin
                err_o   <= 1'b1;
                lock_o  <= 1'b0;
                r_match <= '0;
                r_cnt   <= '0;
                r_state <= S_IDLE;
            end else if (w_done) begin
                snsize_o <= r_sn;
                bpsize_o <= r_bp;
                vlen_o   <= w_vl;
                fpsize_o <= w_fp;
                r_vl     <= w_vl;
                valid_o  <= 1'b1;
                r_match  <= w_match_nxt;
                lock_o   <= w_lock_nxt;
                r_cnt    <= VGA_VB_WIDTH'(1);
                r_state  <= S_SYNC;
            end else begin
                case (r_state)
                    S_IDLE: if (!w_s && !w_v) r_state <= S_ARM;
                    S_ARM: begin
                        if (w_s) begin
                            r_cnt   <= VGA_VB_WIDTH'(1);
                            r_state <= S_SYNC;
                        end
                    end
                    S_SYNC: begin
                        if (w_s) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_sn  <= r_cnt[VGA_TB_WIDTH-1:0];
                            r_cnt <= VGA_VB_WIDTH'(1);
                            if (w_v) begin
                                r_bp    <= '0;
                                r_state <= S_VIS;
                            end else begin
                                r_state <= S_BP;
                            end
                        end
                    end
                    S_BP: begin
                        if (!w_v) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_bp    <= r_cnt[VGA_TB_WIDTH-1:0];
                            r_cnt   <= VGA_VB_WIDTH'(1);
                            r_state <= S_VIS;
                        end
                    end
                    S_VIS: begin
                        if (w_v) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_vl    <= r_cnt;
                            r_cnt   <= VGA_VB_WIDTH'(1);
                            r_state <= S_FP;
                        end
                    end
                    S_FP:    r_cnt   <= r_cnt + 1'b1;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_timmeas.sv
// tb_vga_timmeas: directed + randomized line stream against a line-level
// reference model (expected reports, error cycles and lock from run length).
`timescale 1ns/1ps
module tb_vga_timmeas;

    localparam int TBW   = 8;
    localparam int VBW   = 12;
    localparam int LOCKN = 2;
`ifdef VGA_TIMMEAS_SYNC2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           en    = 1'b0;
    logic           s     = 1'b0;
    logic           v     = 1'b0;
    logic [TBW-1:0] sn_o, bp_o, fp_o;
    logic [VBW-1:0] vl_o;
    logic           valid_o, lock_o, err_o;

    vga_timmeas #(.LOCK_CNT(LOCKN), .VGA_TB_WIDTH(TBW), .VGA_VB_WIDTH(VBW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .sync_i(s), .vis_i(v),
        .snsize_o(sn_o), .bpsize_o(bp_o), .vlen_o(vl_o), .fpsize_o(fp_o),
        .valid_o(valid_o), .lock_o(lock_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed { int sn; int bp; int vl; int fp; } line_t;
    typedef struct { int idx; line_t ln; bit lock; } ev_t;

    ev_t   exp_q[$];
    ev_t   obs_q[$];
    int    eexp_q[$];
    int    eobs_q[$];
    ev_t   mon_ev;
    int    cyc_n = 0;
    int    n_chk = 0;
    int    n_err = 0;

    // line-level model state
    bit    m_open = 0;
    int    m_run  = 0;
    line_t m_cur, m_last, m_rep;

    // record every valid / err pulse with the sample index that produced it
    always @(negedge clk) begin
        if (valid_o) begin
            mon_ev.idx   = cyc_n;
            mon_ev.ln.sn = int'(sn_o);
            mon_ev.ln.bp = int'(bp_o);
            mon_ev.ln.vl = int'(vl_o);
            mon_ev.ln.fp = int'(fp_o);
            mon_ev.lock  = lock_o;
            obs_q.push_back(mon_ev);
        end
        if (err_o) eobs_q.push_back(cyc_n);
    end

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // one sample: present inputs, let the rising edge take them
    task automatic cyc(input logic ss, input logic vv);
        s = ss;
        v = vv;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic kill();
        m_open = 0;
        m_run  = 0;
    endtask

    task automatic expect_line(input int idx, input line_t ln);
        ev_t e;
        if (m_run > 0 && ln == m_last) m_run++;
        else m_run = 1;
        m_last = ln;
        m_rep  = ln;
        e.idx  = idx;
        e.ln   = ln;
        e.lock = (m_run >= LOCKN);
        exp_q.push_back(e);
    endtask

    // a new sync start reports the previous line if that line was armed
    task automatic line_start();
        if (m_open) expect_line(cyc_n + 1 + LAT, m_cur);
    endtask

    task automatic send_line(input line_t ln);
        line_start();
        m_cur  = ln;
        m_open = 1;
        repeat (ln.sn) cyc(1'b1, 1'b0);
        repeat (ln.bp) cyc(1'b0, 1'b0);
        repeat (ln.vl) cyc(1'b0, 1'b1);
        repeat (ln.fp) cyc(1'b0, 1'b0);
    endtask

    task automatic drain();
        ev_t e, o;
        int  x, y;
        while (exp_q.size() > 0 && exp_q[0].idx < cyc_n) begin
            e = exp_q.pop_front();
            o.idx = -1; o.ln = '0; o.lock = 1'b0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            chk("valid_cycle", o.idx, e.idx);
            chk("snsize", o.ln.sn, e.ln.sn);
            chk("bpsize", o.ln.bp, e.ln.bp);
            chk("vlen", o.ln.vl, e.ln.vl);
            chk("fpsize", o.ln.fp, e.ln.fp);
            chk("lock_at_valid", o.lock, e.lock);
        end
        while (eexp_q.size() > 0 && eexp_q[0] < cyc_n) begin
            x = eexp_q.pop_front();
            y = -1;
            if (eobs_q.size() > 0) y = eobs_q.pop_front();
            chk("err_cycle", y, x);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_sn"}, sn_o, 0);
        chk({tag, "_bp"}, bp_o, 0);
        chk({tag, "_vl"}, vl_o, 0);
        chk({tag, "_fp"}, fp_o, 0);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_lock"}, lock_o, 0);
        chk({tag, "_err"}, err_o, 0);
    endtask

    function automatic line_t mk(input int a, input int b, input int c, input int d);
        line_t l;
        l.sn = a; l.bp = b; l.vl = c; l.fp = d;
        return l;
    endfunction

    initial begin
        line_t L, L11, Z, R;
        int    idx;
        L   = mk(4, 3, 10, 2);
        L11 = mk(4, 3, 11, 2);
        Z   = mk(3, 0, 6, 0);

        // reset values
        #1 rst_n = 1'b0;
        en = 1'b1;
        repeat (3) cyc(1'b0, 1'b0);
        chk_outs_zero("reset");
        rst_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0);

        // steady 4/3/10/2 stream: first report at second sync, lock on the next
        repeat (4) send_line(L);
        drain();

        // one longer visible region drops lock, next matching line regains it
        repeat (3) send_line(L11);
        drain();

        // zero back porch and zero front porch
        repeat (3) send_line(Z);
        drain();
        chk("bp_zero", bp_o, 0);
        chk("fp_zero", fp_o, 0);
        chk("err_zero_porch", eobs_q.size(), 0);

        // randomized lines, often repeating the previous one
        R = L;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(3, 0) >= 2)
                R = mk(int'($urandom_range(5, 1)), int'($urandom_range(3, 0)),
                       int'($urandom_range(12, 1)), int'($urandom_range(3, 0)));
            send_line(R);
        end
        drain();

        // visible asserted during sync
        line_start();
        repeat (2) cyc(1'b1, 1'b0);
        eexp_q.push_back(cyc_n + 1 + LAT);
        cyc(1'b1, 1'b1);
        kill();
        repeat (3 + LAT) cyc(1'b0, 1'b0);
        drain();
        chk("lock_after_err", lock_o, 0);
        chk("hold_sn", sn_o, m_rep.sn);
        chk("hold_bp", bp_o, m_rep.bp);
        chk("hold_vl", vl_o, m_rep.vl);
        chk("hold_fp", fp_o, m_rep.fp);
        repeat (3) send_line(L);
        drain();

        // sync held for 2^TBW cycles overflows the sync counter
        line_start();
        idx = cyc_n + 1;
        eexp_q.push_back(idx + (1 << TBW) - 1 + LAT);
        repeat (1 << TBW) cyc(1'b1, 1'b0);
        kill();
        repeat (2 + LAT) cyc(1'b0, 1'b0);
        drain();
        chk("lock_after_ovf", lock_o, 0);

        // enable dropped mid-visible for 3 cycles
        repeat (3) send_line(L);
        drain();
        chk("lock_before_en_drop", lock_o, 1);
        line_start();
        repeat (4) cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b1);
        en = 1'b0;
        kill();
        repeat (3) cyc(1'b0, 1'b1);
        chk("lock_en_low", lock_o, 0);
        en = 1'b1;
        repeat (2) cyc(1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0);
        repeat (3) send_line(L);
        drain();

        // asynchronous reset in the middle of a line
        line_start();
        kill();
        repeat (4) cyc(1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0);
        drain();
        rst_n = 1'b0;
        #1;
        chk_outs_zero("midline_reset");
        m_rep = '0;
        repeat (2) cyc(1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2) cyc(1'b0, 1'b0);
        repeat (3) send_line(L);

        repeat (4) cyc(1'b0, 1'b0);
        drain();
        chk("extra_valid", obs_q.size(), 0);
        chk("extra_err", eobs_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timmeas.md
# vga_timmeas

Measures the horizontal or vertical timing of an incoming VGA-style sync/visible stream and reports it as sync, back-porch, visible and front-porch cycle counts. It is the receive-side counterpart of the timing generator: it consumes a `sync`/`vis` pair of the same form and recovers the sizes that produced them. It also raises a lock flag after a stable run of identical lines and an error pulse on malformed sequences. It sits in the capture and loopback-check path, one instance per axis.

## Interface
- `LOCK_CNT`, default 2: number of consecutive identical measurements needed to assert `lock_o` (range 1..15).
- `clk_i` input 1: clock.
- `rst_n_i` input 1: asynchronous active-low reset.
- `en_i` input 1: measurement enable.
- `sync_i` input 1: sync, active-high.
- `vis_i` input 1: visible-region flag, active-high.
- `snsize_o` output `VGA_TB_WIDTH`: measured sync cycles.
- `bpsize_o` output `VGA_TB_WIDTH`: measured back-porch cycles.
- `vlen_o` output `VGA_VB_WIDTH`: measured visible cycles.
- `fpsize_o` output `VGA_TB_WIDTH`: measured front-porch cycles.
- `valid_o` output 1: one-cycle pulse when a complete line is measured and the outputs are updated.
- `lock_o` output 1: stable timing detected.
- `err_o` output 1: one-cycle pulse on a protocol violation or counter overflow.

## Operation
- Sampled values `s` and `v` are `sync_i` and `vis_i` at each rising `clk_i`, after the optional synchronizer.
- `VGA_VB_WIDTH` >= `VGA_TB_WIDTH`. A single counter `cnt` of width `VGA_VB_WIDTH` is used, plus three shadow registers `sn_r`, `bp_r` and `vl_r`.
- States and transitions:
  - IDLE → ARM when `s=0 & v=0`.
  - ARM → SYNC when `s=1`; set `cnt=1`.
  - SYNC:
    - `s=1 & v=1` → error.
    - `s=1` → increment.
    - `s=0 & v=0` → BP: `sn_r=cnt`, `cnt=1`.
    - `s=0 & v=1` → VIS: `sn_r=cnt`, `bp_r=0`, `cnt=1`.
  - BP:
    - `s=1` → error.
    - `v=0` → increment.
    - `v=1` → VIS: `bp_r=cnt`, `cnt=1`.
  - VIS:
    - `s=1 & v=1` → error.
    - `v=1` → increment.
    - `v=0 & s=0` → FP: `vl_r=cnt`, `cnt=1`.
    - `v=0 & s=1` → line complete with `fp=0`.
  - FP:
    - `v=1` → error.
    - `s=0` → increment.
    - `s=1` → line complete with `fp=cnt`.
- Line complete: load outputs from `sn_r`, `bp_r`, `vl_r` and the front-porch value, pulse `valid_o`, then go to SYNC with `cnt=1`.
- Overflow: an increment that would exceed `2^VGA_TB_WIDTH-1` in SYNC, BP or FP, or `2^VGA_VB_WIDTH-1` in VIS, is an error.
- Error: pulse `err_o`, clear `lock_o` and the match counter, go to IDLE. The size outputs hold their values.
- Lock: on each line complete, compare the new quadruple with the currently held outputs.
  - Equal: increment the match counter, saturating.
  - Different: match counter = 1 and `lock_o=0`.
  - `lock_o=1` once the match counter is >= `LOCK_CNT`.
  - The first line after IDLE sets the match counter to 1.
- `en_i=0`: go to IDLE next cycle and clear `cnt`, the match counter and `lock_o`. No `valid_o` or `err_o`. Size outputs hold.

## Timing
- Reset values: all outputs 0, state IDLE, `cnt=0`, shadows 0.
- Latency from the first `sync_i=1` sample after FP to the outputs updating with `valid_o=1` is 1 cycle (registered outputs). The synchronizer adds 2 cycles.
- `lock_o` rises in the same cycle as the `valid_o` that reaches `LOCK_CNT`.
- An `err_o` caused by a sample is asserted in the following cycle.
- `en_i` falling takes priority over a simultaneous line completion or error: no pulse is issued.
- Reset asserted mid-line returns everything to reset values immediately (asynchronous). The first measurement after reset completes at the second sync rising edge.

## Configuration
- `VGA_TIMMEAS_SYNC2_EN`:
  - Defined: `sync_i` and `vis_i` pass through 2-flop synchronizers (reset to 0) before sampling, and all input-to-output latencies increase by 2 cycles.
  - Undefined: inputs are sampled directly and the latencies are as stated in Timing.

## Test plan
- Lines of sync 4, bp 3, vis 10, fp 2, repeated, with `LOCK_CNT=2` → `valid_o` at the second sync rising edge with 4/3/10/2, and `lock_o=1` at the third edge.
- Same stream, then one line with vis 11 → outputs 4/3/11/2 and `lock_o` drops to 0 at that `valid_o`. Lock is re-acquired after the next matching line.
- bp 0 (vis rises as sync falls) and fp 0 → `bpsize_o=0` and `fpsize_o=0`, and `err_o` stays 0.
- `vis_i=1` during sync → `err_o` pulses once, `lock_o=0`, outputs hold. The next valid line is reported after ARM and one full line.
- Sync held for `2^VGA_TB_WIDTH` cycles → `err_o` pulse, state IDLE.
- `en_i` dropped mid-VIS for 3 cycles then restored → no `valid_o` or `err_o`, `lock_o=0`, and the next `valid_o` comes after a full fresh line. Repeat with `VGA_TIMMEAS_SYNC2_EN` defined and check the extra 2-cycle latency.
